// File: rtl/apb4_master_pkg.sv
// Shared types and defaults for the APB4 initiator.
package apb4_master_pkg;

   // Transfer sequencing: one request walks IDLE -> SETUP -> ACCESS -> RESP.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int unsigned DEF_ADDR_WIDTH  = 32;
   localparam int unsigned DEF_DATA_WIDTH  = 32;
   localparam int unsigned DEF_TIMEOUT_CYC = 256;

   // Width of a counter that must be able to hold the value n (at least 1 bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/apb4_master.sv
// APB4 initiator: turns a valid/ready request into one SETUP/ACCESS transfer
// and returns read data, slave error and a local ACCESS-phase timeout.
module apb4_master
   import apb4_master_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic                    req_write_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] req_strb_i,
   input  logic [2:0]              req_prot_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    rsp_timeout_o,
   output logic [ADDR_WIDTH-1:0]   paddr_o,
   output logic [2:0]              pprot_o,
   output logic                    psel_o,
   output logic                    penable_o,
   output logic                    pwrite_o,
   output logic [DATA_WIDTH-1:0]   pwdata_o,
   output logic [DATA_WIDTH/8-1:0] pstrb_o,
   input  logic                    pready_i,
   input  logic [DATA_WIDTH-1:0]   prdata_i,
   input  logic                    pslverr_i
);

   localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYC);

   state_t                    state_reg;
   logic [CNT_W-1:0]          tmo_cnt_reg;
   logic                      req_ready_reg;
   logic                      psel_reg;
   logic                      penable_reg;
   logic [ADDR_WIDTH-1:0]     paddr_reg;
   logic [2:0]                pprot_reg;
   logic                      pwrite_reg;
   logic [DATA_WIDTH-1:0]     pwdata_reg;
   logic [DATA_WIDTH/8-1:0]   pstrb_reg;
   logic                      rsp_valid_reg;
   logic [DATA_WIDTH-1:0]     rsp_rdata_reg;
   logic                      rsp_err_reg;
   logic                      rsp_timeout_reg;
   logic                      tmo_hit;

   // The ACCESS cycle that would bring the wait count up to the limit aborts
   // the transfer, unless pready arrives in that same cycle.
   assign tmo_hit = (TIMEOUT_CYC != 0) && ((tmo_cnt_reg + CNT_W'(1)) == TMO_LIMIT);

   // Transfer FSM with all bus and response outputs registered; write data and
   // strobes are zeroed at capture time for reads so the bus never shows them.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_reg       <= IDLE;
         tmo_cnt_reg     <= '0;
         req_ready_reg   <= 1'b1;
         psel_reg        <= 1'b0;
         penable_reg     <= 1'b0;
         paddr_reg       <= '0;
         pprot_reg       <= '0;
         pwrite_reg      <= 1'b0;
         pwdata_reg      <= '0;
         pstrb_reg       <= '0;
         rsp_valid_reg   <= 1'b0;
         rsp_rdata_reg   <= '0;
         rsp_err_reg     <= 1'b0;
         rsp_timeout_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid_i) begin
                  state_reg     <= SETUP;
                  req_ready_reg <= 1'b0;
                  psel_reg      <= 1'b1;
                  penable_reg   <= 1'b0;
                  tmo_cnt_reg   <= '0;
                  paddr_reg     <= req_addr_i;
                  pprot_reg     <= req_prot_i;
                  pwrite_reg    <= req_write_i;
                  pwdata_reg    <= req_write_i ? req_wdata_i : '0;
                  pstrb_reg     <= req_write_i ? req_strb_i : '0;
               end
            end
            SETUP: begin
               state_reg   <= ACCESS;
               penable_reg <= 1'b1;
            end
            ACCESS: begin
               if (pready_i) begin
                  state_reg       <= RESP;
                  psel_reg        <= 1'b0;
                  penable_reg     <= 1'b0;
                  rsp_valid_reg   <= 1'b1;
                  rsp_rdata_reg   <= pwrite_reg ? '0 : prdata_i;
                  rsp_err_reg     <= pslverr_i;
                  rsp_timeout_reg <= 1'b0;
               end else if (tmo_hit) begin
                  state_reg       <= RESP;
                  psel_reg        <= 1'b0;
                  penable_reg     <= 1'b0;
                  rsp_valid_reg   <= 1'b1;
                  rsp_rdata_reg   <= '0;
                  rsp_err_reg     <= 1'b1;
                  rsp_timeout_reg <= 1'b1;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state_reg     <= IDLE;
                  rsp_valid_reg <= 1'b0;
                  req_ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               req_ready_reg <= 1'b1;
               psel_reg      <= 1'b0;
               penable_reg   <= 1'b0;
               rsp_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o   = req_ready_reg;
   assign psel_o        = psel_reg;
   assign penable_o     = penable_reg;
   assign paddr_o       = paddr_reg;
   assign pprot_o       = pprot_reg;
   assign pwrite_o      = pwrite_reg;
   assign pwdata_o      = pwdata_reg;
   assign pstrb_o       = pstrb_reg;
   assign rsp_valid_o   = rsp_valid_reg;
   assign rsp_rdata_o   = rsp_rdata_reg;
   assign rsp_err_o     = rsp_err_reg;
   assign rsp_timeout_o = rsp_timeout_reg;

endmodule

// File: tb/tb_apb4_master.sv
// Directed bench for apb4_master with a 4-cycle ACCESS timeout.
module tb_apb4_master;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          pclk;
   logic          preset;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [AW-1:0] req_addr_i;
   logic          req_write_i;
   logic [DW-1:0] req_wdata_i;
   logic [3:0]    req_strb_i;
   logic [2:0]    req_prot_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [DW-1:0] rsp_rdata_o;
   logic          rsp_err_o;
   logic          rsp_timeout_o;
   logic [AW-1:0] paddr_o;
   logic [2:0]    pprot_o;
   logic          psel_o;
   logic          penable_o;
   logic          pwrite_o;
   logic [DW-1:0] pwdata_o;
   logic [3:0]    pstrb_o;
   logic          pready_i;
   logic [DW-1:0] prdata_i;
   logic          pslverr_i;

   int n_checks = 0;
   int n_errors = 0;

   apb4_master #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .TIMEOUT_CYC (4)
   ) dut (
      .pclk          (pclk),
      .preset        (preset),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_addr_i    (req_addr_i),
      .req_write_i   (req_write_i),
      .req_wdata_i   (req_wdata_i),
      .req_strb_i    (req_strb_i),
      .req_prot_i    (req_prot_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_rdata_o   (rsp_rdata_o),
      .rsp_err_o     (rsp_err_o),
      .rsp_timeout_o (rsp_timeout_o),
      .paddr_o       (paddr_o),
      .pprot_o       (pprot_o),
      .psel_o        (psel_o),
      .penable_o     (penable_o),
      .pwrite_o      (pwrite_o),
      .pwdata_o      (pwdata_o),
      .pstrb_o       (pstrb_o),
      .pready_i      (pready_i),
      .prdata_i      (prdata_i),
      .pslverr_i     (pslverr_i)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge pclk);
   endtask

   task automatic request(input logic [AW-1:0] addr, input logic wr,
                          input logic [DW-1:0] wdata, input logic [3:0] strb);
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      req_write_i = wr;
      req_wdata_i = wdata;
      req_strb_i  = strb;
   endtask

   initial begin
      preset      = 1'b1;
      req_valid_i = 1'b0;
      req_addr_i  = '0;
      req_write_i = 1'b0;
      req_wdata_i = '0;
      req_strb_i  = '0;
      req_prot_i  = '0;
      rsp_ready_i = 1'b1;
      pready_i    = 1'b0;
      prdata_i    = '0;
      pslverr_i   = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_psel", psel_o, 0);
      chk("rst_penable", penable_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_rsp_err", rsp_err_o, 0);
      preset = 1'b0;
      tick();
      chk("rst_req_ready", req_ready_o, 1);
      $display("txn reset: done");

      // Zero-wait write
      request(32'h0000_0008, 1'b1, 32'h0000_00FF, 4'hF);
      req_prot_i = 3'b010;
      pready_i   = 1'b1;
      prdata_i   = 32'h0000_1234;
      tick();
      req_valid_i = 1'b0;
      chk("wr_setup_psel", psel_o, 1);
      chk("wr_setup_penable", penable_o, 0);
      chk("wr_setup_paddr", paddr_o, 32'h8);
      chk("wr_setup_pwrite", pwrite_o, 1);
      chk("wr_setup_pwdata", pwdata_o, 32'hFF);
      chk("wr_setup_pstrb", pstrb_o, 4'hF);
      chk("wr_setup_pprot", pprot_o, 3'b010);
      chk("wr_setup_req_ready", req_ready_o, 0);
      tick();
      chk("wr_access_psel", psel_o, 1);
      chk("wr_access_penable", penable_o, 1);
      tick();
      chk("wr_resp_valid", rsp_valid_o, 1);
      chk("wr_resp_err", rsp_err_o, 0);
      chk("wr_resp_timeout", rsp_timeout_o, 0);
      chk("wr_resp_rdata", rsp_rdata_o, 0);
      chk("wr_resp_psel", psel_o, 0);
      chk("wr_resp_penable", penable_o, 0);
      tick();
      chk("wr_idle_rsp_valid", rsp_valid_o, 0);
      chk("wr_idle_req_ready", req_ready_o, 1);
      $display("txn write 0x8 data 0xff: done");

      // Read with 3 wait states; pready on the 4th ACCESS cycle beats the timeout
      req_prot_i = 3'b000;
      request(32'h0000_0004, 1'b0, 32'hDEAD_BEEF, 4'hF);
      pready_i = 1'b0;
      prdata_i = 32'hA5A5_0001;
      tick();
      req_valid_i = 1'b0;
      chk("rd_setup_paddr", paddr_o, 32'h4);
      chk("rd_setup_pstrb", pstrb_o, 0);
      chk("rd_setup_pwdata", pwdata_o, 0);
      chk("rd_setup_pwrite", pwrite_o, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rd_access_penable", penable_o, 1);
         chk("rd_access_paddr", paddr_o, 32'h4);
         chk("rd_access_pstrb", pstrb_o, 0);
         if (i == 3) pready_i = 1'b1;
      end
      tick();
      pready_i = 1'b0;
      chk("rd_resp_valid", rsp_valid_o, 1);
      chk("rd_resp_rdata", rsp_rdata_o, 32'hA5A5_0001);
      chk("rd_resp_err", rsp_err_o, 0);
      chk("rd_resp_timeout", rsp_timeout_o, 0);
      tick();
      $display("txn read 0x4 with 3 waits: rdata 0x%08h", 32'hA5A5_0001);

      // Read with slave error
      request(32'h0000_000C, 1'b0, 32'h0, 4'h0);
      pready_i  = 1'b1;
      pslverr_i = 1'b1;
      prdata_i  = 32'h0000_0055;
      tick();
      req_valid_i = 1'b0;
      tick();
      tick();
      chk("slverr_resp_valid", rsp_valid_o, 1);
      chk("slverr_resp_err", rsp_err_o, 1);
      chk("slverr_resp_timeout", rsp_timeout_o, 0);
      chk("slverr_resp_rdata", rsp_rdata_o, 32'h55);
      pslverr_i = 1'b0;
      tick();
      $display("txn read 0xc with pslverr: done");

      // Timeout: pready stuck low for the whole ACCESS window
      request(32'h0000_0010, 1'b0, 32'h0, 4'h0);
      pready_i = 1'b0;
      prdata_i = 32'h0000_0077;
      tick();
      req_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("tmo_access_psel", psel_o, 1);
         chk("tmo_access_penable", penable_o, 1);
      end
      tick();
      chk("tmo_resp_psel", psel_o, 0);
      chk("tmo_resp_valid", rsp_valid_o, 1);
      chk("tmo_resp_err", rsp_err_o, 1);
      chk("tmo_resp_timeout", rsp_timeout_o, 1);
      chk("tmo_resp_rdata", rsp_rdata_o, 0);
      tick();
      chk("tmo_idle_rsp_valid", rsp_valid_o, 0);
      $display("txn read 0x10 timeout: done");

      // Response back-pressure; a new request waits for the handshake
      rsp_ready_i = 1'b0;
      request(32'h0000_0020, 1'b1, 32'h0000_0001, 4'h1);
      pready_i  = 1'b1;
      pslverr_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      tick();
      tick();
      pslverr_i = 1'b0;
      request(32'h0000_0024, 1'b0, 32'h0, 4'h0);
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", rsp_valid_o, 1);
         chk("bp_rsp_err", rsp_err_o, 1);
         chk("bp_req_ready", req_ready_o, 0);
         chk("bp_psel", psel_o, 0);
         tick();
      end
      chk("bp_rsp_valid_last", rsp_valid_o, 1);
      rsp_ready_i = 1'b1;
      tick();
      chk("bp_idle_rsp_valid", rsp_valid_o, 0);
      chk("bp_idle_req_ready", req_ready_o, 1);
      chk("bp_idle_psel", psel_o, 0);
      tick();
      req_valid_i = 1'b0;
      chk("bp_next_psel", psel_o, 1);
      chk("bp_next_paddr", paddr_o, 32'h24);
      chk("bp_next_pwrite", pwrite_o, 0);
      tick();
      tick();
      tick();
      $display("txn write 0x20 with 5-cycle rsp stall: done");

      // Reset asserted in the middle of ACCESS
      request(32'h0000_0030, 1'b1, 32'h1111_2222, 4'hF);
      pready_i = 1'b0;
      tick();
      req_valid_i = 1'b0;
      tick();
      chk("mrst_access_penable", penable_o, 1);
      #1 preset = 1'b1;
      #1;
      chk("mrst_psel", psel_o, 0);
      chk("mrst_penable", penable_o, 0);
      chk("mrst_rsp_valid", rsp_valid_o, 0);
      tick();
      preset = 1'b0;
      tick();
      chk("mrst_req_ready", req_ready_o, 1);
      chk("mrst_idle_rsp_valid", rsp_valid_o, 0);
      request(32'h0000_0040, 1'b0, 32'h0, 4'h0);
      pready_i = 1'b1;
      prdata_i = 32'hCAFE_F00D;
      tick();
      req_valid_i = 1'b0;
      chk("mrst_next_psel", psel_o, 1);
      tick();
      tick();
      chk("mrst_next_rsp_valid", rsp_valid_o, 1);
      chk("mrst_next_rdata", rsp_rdata_o, 32'hCAFE_F00D);
      chk("mrst_next_err", rsp_err_o, 0);
      tick();
      $display("txn reset mid-access then read 0x40: done");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/apb4_master.md
Name: apb4_master

Overview:
- APB4 initiator: converts a simple valid/ready request/response command interface into APB4 SETUP/ACCESS transfers toward peripheral slaves (GPIO, timers, etc.).
- Sits between an internal bus-bridge/CPU-side requester and the APB4 slave fabric.
- One outstanding transfer; captures read data, slave error, and a local timeout.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width (multiple of 8).
- TIMEOUT_CYC, 256, max ACCESS-phase cycles awaiting pready; 0 disables timeout.

Ports:
- pclk  in  1  clock
- preset  in  1  asynchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  ADDR_WIDTH  byte address
- req_write_i  in  1  1=write, 0=read
- req_wdata_i  in  DATA_WIDTH  write data
- req_strb_i  in  DATA_WIDTH/8  write byte strobes
- req_prot_i  in  3  pprot value
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes/timeout)
- rsp_err_o  out  1  pslverr or timeout
- rsp_timeout_o  out  1  transfer aborted by timeout
- paddr_o  out  ADDR_WIDTH  APB address
- pprot_o  out  3  APB protection
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- pwdata_o  out  DATA_WIDTH  APB write data
- pstrb_o  out  DATA_WIDTH/8  APB strobes
- pready_i  in  1  slave ready
- prdata_i  in  DATA_WIDTH  slave read data
- pslverr_i  in  1  slave error

Behaviour:
- Reset (async, preset=1): state IDLE; all outputs 0 except req_ready_o=1 once out of reset; timeout counter 0.
- FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE: req_ready_o=1; on req_valid_i, register addr/write/wdata/strb/prot; next SETUP. req_ready_o=0 in all other states (single outstanding).
- SETUP (exactly 1 cycle): psel_o=1, penable_o=0, address/control/data from registers; next ACCESS.
- ACCESS: psel_o=1, penable_o=1; paddr/pwrite/pwdata/pstrb/pprot held stable from SETUP until exit. On pready_i=1: capture prdata_i (reads only; writes store 0), pslverr_i -> rsp_err; next RESP.
- pstrb_o forced 0 for reads; pwdata_o driven 0 for reads.
- Timeout: counter clears on SETUP entry, increments each ACCESS cycle with pready_i=0. When it reaches TIMEOUT_CYC (and TIMEOUT_CYC!=0), abort: next RESP with rsp_err=1, rsp_timeout=1, rdata=0. If pready_i=1 in the same cycle the limit is reached, pready wins (normal completion).
- RESP: psel_o=penable_o=0; rsp_valid_o=1, rsp_* stable until rsp_ready_i=1; then IDLE. rsp_valid_o never drops without handshake.
- Latency (zero-wait slave, rsp_ready_i=1): request accepted edge N; SETUP cycle N+1; ACCESS cycle N+2; rsp_valid_o high cycle N+3; next request accepted earliest cycle N+4.
- psel_o/penable_o deassert in IDLE and RESP; no back-to-back APB transfers without IDLE.
- Reset mid-transfer: bus signals drop immediately (async); pending response discarded.
- prdata_i/pslverr_i ignored outside ACCESS with pready_i=1.

Decomposition:
- Shared package apb4_master_pkg: state enum (IDLE, SETUP, ACCESS, RESP), default widths, TIMEOUT default.
- Existing shared dffr/dffer register primitives for state, request capture, and response holding.
- No sub-module; timeout counter inline.

Test Plan:
- Write 0x0000_0008 data 0x0000_00FF strb 0xF, slave pready=1 -> psel rises cycle N+1, penable N+2, pwdata=0xFF, rsp_valid N+3, rsp_err=0.
- Read 0x0000_0004, slave inserts 3 wait states, prdata=0xA5A5_0001 -> ACCESS lasts 4 cycles, paddr stable throughout, rsp_rdata=0xA5A5_0001, pstrb=0.
- Read with pslverr=1 at pready -> rsp_err=1, rsp_timeout=0.
- TIMEOUT_CYC=4, pready stuck 0 -> abort after 4 ACCESS cycles, psel drops, rsp_err=1, rsp_timeout=1, rdata=0; pready=1 on 4th cycle -> normal completion.
- rsp_ready held 0 for 5 cycles -> rsp_valid/data stable, req_ready=0, new req_valid not accepted until handshake.
- preset asserted during ACCESS -> psel/penable/rsp_valid 0 same cycle, req_ready=1 after release, next transfer completes normally.
